// File: rtl/paging_mmu.sv
// Paging unit: translates virtual addresses through an on-chip page table,
// with a valid/ready request/response handshake, permission checks, a sticky
// fault register, a clocked table write port and a post-reset init sequencer.
module paging_mmu #(
  parameter int unsigned VA_W      = 16,
  parameter int unsigned PAGE_BITS = 6,
  parameter int unsigned FRAME_W   = 10,
  parameter int unsigned PTE_W     = 16,
  parameter logic [PTE_W-FRAME_W-1:0] INIT_FLAGS = 6'b000110
) (
  input  logic                                 Clk,
  input  logic                                 Rst_n,
  input  logic                                 WE,
  input  logic [PAGE_BITS-1:0]                 WPTI,
  input  logic [PTE_W-1:0]                     WPTE,
  input  logic [PAGE_BITS-1:0]                 RPTI,
  output logic [PTE_W-1:0]                     RPTE,
  input  logic                                 ReqValid,
  output logic                                 ReqReady,
  input  logic                                 ReqWrite,
  input  logic [VA_W-1:0]                      VAddr,
  output logic                                 RspValid,
  input  logic                                 RspReady,
  output logic [FRAME_W+VA_W-PAGE_BITS-1:0]    LAddr,
  output logic                                 Fault,
  output logic [1:0]                           FaultCode,
  output logic                                 FaultPend,
  output logic [VA_W-1:0]                      FaultVAddr,
  input  logic                                 FaultClr,
  output logic                                 Busy
);

  localparam int unsigned NPAGES = 2 ** PAGE_BITS;
  localparam int unsigned OFF_W  = VA_W - PAGE_BITS;
  localparam int unsigned LA_W   = FRAME_W + OFF_W;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [PAGE_BITS-1:0]   init_cnt_q, init_cnt_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [LA_W-1:0]        laddr_q, laddr_d;
  logic                   fault_q, fault_d;
  logic [1:0]             fault_code_q, fault_code_d;
  logic                   fault_pend_q, fault_pend_d;
  logic [VA_W-1:0]        fault_vaddr_q, fault_vaddr_d;

  logic [PTE_W-1:0]       pt_q [NPAGES];

  logic                   req_ready;
  logic                   accept;
  logic [PAGE_BITS-1:0]   req_idx;
  logic [FRAME_W-1:0]     req_frame;
  logic                   req_present;
  logic                   req_writable;
  logic [1:0]             req_code;
  logic                   tbl_we;
  logic [PAGE_BITS-1:0]   tbl_wa;
  logic [PTE_W-1:0]       tbl_wd;

  // Handshake, lookup, permission check and table write-port selection
  always_comb begin
    req_ready    = (state_q == ST_RUN) & ~WE & (~rsp_valid_q | RspReady);
    accept       = ReqValid & req_ready;
    req_idx      = VAddr[VA_W-1:OFF_W];
    req_frame    = pt_q[req_idx][FRAME_W-1:0];
    req_present  = pt_q[req_idx][FRAME_W+2];
    req_writable = pt_q[req_idx][FRAME_W+1];
    req_code     = 2'b00;
    if (!req_present)                 req_code = 2'b01;
    else if (ReqWrite && !req_writable) req_code = 2'b10;

    // Init writes are held off while reset is asserted so reset never alters the table
    if (state_q == ST_INIT) begin
      tbl_we = Rst_n;
      tbl_wa = init_cnt_q;
      tbl_wd = {INIT_FLAGS, FRAME_W'(init_cnt_q)};
    end else begin
      tbl_we = WE;
      tbl_wa = WPTI;
      tbl_wd = WPTE;
    end
  end

  // Next state for init sequencer, response register and sticky fault register
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    rsp_valid_d   = rsp_valid_q;
    laddr_d       = laddr_q;
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    fault_pend_d  = fault_pend_q;
    fault_vaddr_d = fault_vaddr_q;

    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (&init_cnt_q) state_d = ST_RUN;
    end

    if (accept) begin
      rsp_valid_d  = 1'b1;
      laddr_d      = {req_frame, VAddr[OFF_W-1:0]};
      fault_d      = |req_code;
      fault_code_d = req_code;
    end else if (rsp_valid_q && RspReady) begin
      rsp_valid_d = 1'b0;
    end

    // A new fault outranks FaultClr; with clear present the new address re-latches
    if (accept && (|req_code)) begin
      fault_pend_d = 1'b1;
      if (!fault_pend_q || FaultClr) fault_vaddr_d = VAddr;
    end else if (FaultClr) begin
      fault_pend_d  = 1'b0;
      fault_vaddr_d = '0;
    end
  end

  // Control and response state
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= ST_INIT;
      init_cnt_q    <= '0;
      rsp_valid_q   <= 1'b0;
      laddr_q       <= '0;
      fault_q       <= 1'b0;
      fault_code_q  <= 2'b00;
      fault_pend_q  <= 1'b0;
      fault_vaddr_q <= '0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      laddr_q       <= laddr_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      fault_pend_q  <= fault_pend_d;
      fault_vaddr_q <= fault_vaddr_d;
    end
  end

  // Page table storage; contents survive reset
  always_ff @(posedge Clk) begin
    if (tbl_we) pt_q[tbl_wa] <= tbl_wd;
  end

  assign RPTE       = pt_q[RPTI];
  assign ReqReady   = req_ready;
  assign RspValid   = rsp_valid_q;
  assign LAddr      = laddr_q;
  assign Fault      = fault_q;
  assign FaultCode  = fault_code_q;
  assign FaultPend  = fault_pend_q;
  assign FaultVAddr = fault_vaddr_q;
  assign Busy       = (state_q == ST_INIT);

endmodule
